// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_pkg                                                  |
// | Purpose  : Shared constants and helpers for the fifo_sync_fwft slice |
// |            (read-mode encodings, depth helper).                      |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter of fifo_sync_fwft.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Number of words held by a FIFO with the given address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_fwft_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_sync_fwft_if                                         |
// | Purpose  : Bundles the write, read, threshold and status signals of  |
// |            fifo_sync_fwft.                                           |
// | Modports : master - producer/consumer side (drives requests)         |
// |            slave  - FIFO side (drives data out and status)           |
// | Signals  : flush, err_clr, wr_data/wr_en, rd_en, af/ae_thresh (in to |
// |            FIFO); full, almost_full, rd_data, rd_valid, empty,       |
// |            almost_empty, fifo_count, overflow, underflow (out)       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface fifo_sync_fwft_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);

  logic                  flush;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, err_clr, wr_data, wr_en, rd_en, af_thresh, ae_thresh,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           fifo_count, overflow, underflow
  );

  modport slave (
    input  flush, err_clr, wr_data, wr_en, rd_en, af_thresh, ae_thresh,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           fifo_count, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_ram                                                  |
// | Purpose  : Simple dual-port storage, synchronous read-first read     |
// |            port, written to infer block RAM. Contents not reset.     |
// | Ports    : clk            - clock                                    |
// |            wr_addr/wr_data/wr_en - write port                        |
// |            rd_addr/rd_en  - read request, rd_data valid next cycle   |
// |            rd_data        - registered read word (holds when idle)   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:fifo_depth(ADDR_WIDTH)-1];

  // No reset on the array or the read register so the tools can map both
  // onto a block RAM and its output latch.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_sync_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_sync_fwft                                            |
// | Purpose  : Single-clock FIFO with standard or first-word-fall-through|
// |            read mode, sticky overflow/underflow, synchronous flush   |
// |            and programmable almost-full/almost-empty thresholds.     |
// | Ports    : clk    - clock, rising edge                               |
// |            resetn - asynchronous active-low reset                    |
// |            bus    - fifo_sync_fwft_if.slave (data, handshake, status)|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic           clk,
  input  logic           resetn,
  fifo_sync_fwft_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] c_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit; the RAM uses the low bits only.
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;   // write accepted this cycle
  logic                  w_pop;      // a word leaves the FIFO (count decrement)
  logic                  w_ram_rd;   // RAM read issued, read pointer advances
  logic                  w_ram_has;  // RAM holds words not yet read out
  logic                  w_ov_evt;
  logic                  w_un_evt;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_valid;

  assign w_full    = (r_count == c_DEPTH);
  assign w_ram_has = (r_wr_ptr != r_rd_ptr);
  assign w_wr_acc  = bus.wr_en & ~w_full & ~bus.flush;
  assign w_ov_evt  = bus.wr_en & w_full & ~bus.flush;
  assign w_un_evt  = bus.rd_en & w_empty & ~bus.flush;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (bus.wr_data),
    .wr_en   (w_wr_acc),
    .rd_en   (w_ram_rd),
    .rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (w_ram_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ONE;
      end
      if (w_ram_rd) begin
        r_rd_ptr <= r_rd_ptr + c_ONE;
      end
      r_count <= r_count + {{ADDR_WIDTH{1'b0}}, w_wr_acc}
                         - {{ADDR_WIDTH{1'b0}}, w_pop};
    end
  end

  // Sticky error flags: a new event in the clear cycle wins over the clear.
  // Flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~bus.err_clr) | w_ov_evt;
      r_underflow <= (r_underflow & ~bus.err_clr) | w_un_evt;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Two-stage prefetch: RAM read register (r_ram_vld qualifies w_ram_q)
    // feeding the output register that is presented to the consumer.
    logic                  r_ram_vld;
    logic                  r_out_vld;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_ram_take;

    assign w_pop      = bus.rd_en & r_out_vld & ~bus.flush;
    // The RAM stage moves forward whenever the output slot is free or
    // being vacated by a pop this cycle.
    assign w_ram_take = r_ram_vld & (~r_out_vld | w_pop);
    assign w_ram_rd   = w_ram_has & (~r_ram_vld | w_ram_take) & ~bus.flush;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_ram_vld  <= 1'b0;
        r_out_vld  <= 1'b0;
        r_out_data <= '0;
      end else if (bus.flush) begin
        r_ram_vld  <= 1'b0;
        r_out_vld  <= 1'b0;
      end else begin
        if (w_ram_rd) begin
          r_ram_vld <= 1'b1;
        end else if (w_ram_take) begin
          r_ram_vld <= 1'b0;
        end
        if (w_ram_take) begin
          r_out_vld  <= 1'b1;
          r_out_data <= w_ram_q;
        end else if (w_pop) begin
          r_out_vld  <= 1'b0;
        end
      end
    end

    assign w_empty    = ~r_out_vld;
    assign w_rd_valid = r_out_vld;
    assign w_rd_data  = r_out_data;
  end else begin : g_std
    // Standard mode reads straight from the RAM output register. That
    // register has no reset, so r_seen masks it to zero until the first
    // read after reset; afterwards it simply holds the last word read.
    logic r_valid;
    logic r_seen;

    assign w_empty  = ~w_ram_has;
    assign w_pop    = bus.rd_en & w_ram_has & ~bus.flush;
    assign w_ram_rd = w_pop;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_valid <= 1'b0;
        r_seen  <= 1'b0;
      end else begin
        r_valid <= w_pop;
        if (w_pop) begin
          r_seen <= 1'b1;
        end
      end
    end

    assign w_rd_valid = r_valid;
    assign w_rd_data  = r_seen ? w_ram_q : '0;
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= bus.af_thresh);
  assign bus.almost_empty = (r_count <= bus.ae_thresh);
  assign bus.fifo_count   = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.rd_valid     = w_rd_valid;
  assign bus.rd_data      = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fifo_sync_fwft                                         |
// | Purpose  : Directed self-checking bench for fifo_sync_fwft. One      |
// |            standard-mode instance (16x16) and one FWFT instance      |
// |            (16x8) share clock and reset.                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_fifo_sync_fwft;
  import fifo_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_sync_fwft_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) s_if ();
  fifo_sync_fwft_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) f_if ();

  fifo_sync_fwft #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(FIFO_MODE_STD)) u_std (
    .clk    (clk),
    .resetn (resetn),
    .bus    (s_if)
  );

  fifo_sync_fwft #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .FWFT(FIFO_MODE_FWFT)) u_fw (
    .clk    (clk),
    .resetn (resetn),
    .bus    (f_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.flush = 1'b0; s_if.err_clr = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
    s_if.wr_data = '0; s_if.af_thresh = 5'd14; s_if.ae_thresh = 5'd2;
    f_if.flush = 1'b0; f_if.err_clr = 1'b0; f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
    f_if.wr_data = '0; f_if.af_thresh = 4'd6; f_if.ae_thresh = 4'd1;

    // ---- reset state
    #2 resetn = 1'b0;
    tick(); tick();
    chk("rst_count", s_if.fifo_count, 0);
    chk("rst_empty", s_if.empty, 1);
    chk("rst_full", s_if.full, 0);
    chk("rst_rd_valid", s_if.rd_valid, 0);
    chk("rst_rd_data", s_if.rd_data, 0);
    chk("rst_overflow", s_if.overflow, 0);
    chk("rst_underflow", s_if.underflow, 0);
    chk("rst_fw_empty", f_if.empty, 1);
    chk("rst_fw_rd_valid", f_if.rd_valid, 0);
    chk("rst_fw_rd_data", f_if.rd_data, 0);
    resetn = 1'b1;
    tick();

    // ---- standard: fill 1..16, thresholds on the way up
    for (int i = 1; i <= 16; i++) begin
      s_if.wr_en = 1'b1; s_if.wr_data = 16'(i);
      tick();
      chk("std_fill_count", s_if.fifo_count, i);
      if (i == 13) chk("af_at_13", s_if.almost_full, 0);
      if (i == 14) chk("af_at_14", s_if.almost_full, 1);
      if (i == 15) chk("full_at_15", s_if.full, 0);
    end
    chk("std_full", s_if.full, 1);
    // 17th write is dropped and flagged
    s_if.wr_data = 16'h0011;
    tick();
    s_if.wr_en = 1'b0;
    chk("std_overflow", s_if.overflow, 1);
    chk("std_ovf_count", s_if.fifo_count, 16);

    // ---- standard: drain, data one cycle after each read
    for (int i = 1; i <= 16; i++) begin
      s_if.rd_en = 1'b1;
      tick();
      chk("std_rd_valid", s_if.rd_valid, 1);
      chk("std_rd_data", s_if.rd_data, i);
      chk("std_drain_count", s_if.fifo_count, 16 - i);
      if (i == 13) chk("ae_at_3", s_if.almost_empty, 0);
      if (i == 14) chk("ae_at_2", s_if.almost_empty, 1);
    end
    s_if.rd_en = 1'b0;
    tick();
    chk("std_valid_drop", s_if.rd_valid, 0);
    chk("std_empty_end", s_if.empty, 1);
    chk("std_data_hold", s_if.rd_data, 16'h0010);

    // ---- underflow and err_clr
    s_if.rd_en = 1'b1;
    tick();
    chk("udf_set", s_if.underflow, 1);
    chk("udf_data_hold", s_if.rd_data, 16'h0010);
    chk("udf_no_valid", s_if.rd_valid, 0);
    s_if.err_clr = 1'b1;
    tick();
    chk("udf_set_wins", s_if.underflow, 1);
    chk("ovf_cleared", s_if.overflow, 0);
    s_if.rd_en = 1'b0;
    tick();
    s_if.err_clr = 1'b0;
    chk("udf_cleared", s_if.underflow, 0);

    // ---- flush with 5 words held
    for (int i = 0; i < 5; i++) begin
      s_if.wr_en = 1'b1; s_if.wr_data = 16'(16'h00A0 + i);
      tick();
    end
    s_if.wr_en = 1'b0;
    chk("pre_flush_count", s_if.fifo_count, 5);
    s_if.flush = 1'b1;
    tick();
    s_if.flush = 1'b0;
    chk("flush_count", s_if.fifo_count, 0);
    chk("flush_empty", s_if.empty, 1);
    chk("flush_rd_valid", s_if.rd_valid, 0);
    chk("flush_data_hold", s_if.rd_data, 16'h0010);
    s_if.wr_en = 1'b1; s_if.wr_data = 16'h0055;
    tick();
    s_if.wr_en = 1'b0;
    chk("post_flush_count", s_if.fifo_count, 1);
    s_if.rd_en = 1'b1;
    tick();
    s_if.rd_en = 1'b0;
    chk("post_flush_data", s_if.rd_data, 16'h0055);
    chk("post_flush_empty", s_if.empty, 1);

    // ---- reset mid-burst
    s_if.rd_en = 1'b1;
    tick();
    s_if.rd_en = 1'b0;
    chk("pre_rst_udf", s_if.underflow, 1);
    for (int i = 0; i < 3; i++) begin
      s_if.wr_en = 1'b1; s_if.wr_data = 16'(16'h00B0 + i);
      tick();
    end
    s_if.wr_data = 16'h00B3;
    #1 resetn = 1'b0;
    #1;
    chk("midrst_count", s_if.fifo_count, 0);
    chk("midrst_empty", s_if.empty, 1);
    chk("midrst_rd_valid", s_if.rd_valid, 0);
    chk("midrst_udf", s_if.underflow, 0);
    s_if.wr_en = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    s_if.wr_en = 1'b1; s_if.wr_data = 16'h00C1;
    tick();
    s_if.wr_en = 1'b0;
    chk("post_rst_count", s_if.fifo_count, 1);
    s_if.rd_en = 1'b1;
    tick();
    s_if.rd_en = 1'b0;
    chk("post_rst_data", s_if.rd_data, 16'h00C1);
    chk("post_rst_empty", s_if.empty, 1);

    // ---- FWFT: single-word latency
    f_if.wr_en = 1'b1; f_if.wr_data = 16'hBEEF;
    tick();
    f_if.wr_en = 1'b0;
    chk("fw_lat_e0_valid", f_if.rd_valid, 0);
    chk("fw_lat_count", f_if.fifo_count, 1);
    tick();
    chk("fw_lat_e1_valid", f_if.rd_valid, 0);
    tick();
    chk("fw_lat_e2_valid", f_if.rd_valid, 1);
    chk("fw_lat_e2_data", f_if.rd_data, 16'hBEEF);
    chk("fw_lat_e2_empty", f_if.empty, 0);
    f_if.rd_en = 1'b1;
    tick();
    f_if.rd_en = 1'b0;
    chk("fw_pop_valid", f_if.rd_valid, 0);
    chk("fw_pop_empty", f_if.empty, 1);
    chk("fw_pop_count", f_if.fifo_count, 0);

    // ---- FWFT: 8 back-to-back pops
    for (int i = 0; i < 8; i++) begin
      f_if.wr_en = 1'b1; f_if.wr_data = 16'(16'h0100 + i);
      tick();
    end
    f_if.wr_en = 1'b0;
    chk("fw_full", f_if.full, 1);
    chk("fw_full_count", f_if.fifo_count, 8);
    tick();
    chk("fw_head0", f_if.rd_data, 16'h0100);
    for (int k = 1; k <= 8; k++) begin
      f_if.rd_en = 1'b1;
      tick();
      chk("fw_b2b_count", f_if.fifo_count, 8 - k);
      if (k < 8) begin
        chk("fw_b2b_valid", f_if.rd_valid, 1);
        chk("fw_b2b_data", f_if.rd_data, 16'h0100 + k);
      end else begin
        chk("fw_b2b_last", f_if.rd_valid, 0);
      end
    end
    tick();
    f_if.rd_en = 1'b0;
    chk("fw_udf", f_if.underflow, 1);
    chk("fw_udf_hold", f_if.rd_data, 16'h0107);

    // ---- FWFT wrap-around at steady count 3
    for (int i = 0; i < 3; i++) begin
      f_if.wr_en = 1'b1; f_if.wr_data = 16'(16'h0200 + i);
      tick();
    end
    f_if.wr_en = 1'b0;
    tick(); tick();
    chk("wrap_start_count", f_if.fifo_count, 3);
    for (int k = 0; k < 40; k++) begin
      chk("wrap_valid", f_if.rd_valid, 1);
      chk("wrap_head", f_if.rd_data, 16'h0200 + k);
      f_if.wr_en = 1'b1; f_if.wr_data = 16'(16'h0203 + k);
      f_if.rd_en = 1'b1;
      tick();
      chk("wrap_count", f_if.fifo_count, 3);
    end
    f_if.wr_en = 1'b0;
    f_if.rd_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
